// File: rtl/sub_pack_rx_if.sv
// Stream bundle between the sub1 narrow sender, the packer and the sub2 consumers.
// The narrow side (i_sig_valid/o_sig_ready/i_sig_data/i_sig_last) carries DW-bit
// words. The wide side (o_sig_valid/i_sig_ready/o_sig_data/o_sig_keep/o_sig_last)
// carries packed words. Defining SUB_PACK_RX_PARITY_EN adds i_sig_par and o_par_err.
// Modports: slave = packer view; master = sender/consumer (testbench) view.
interface sub_pack_rx_if #(
  parameter int DW    = 8,
  parameter int RATIO = 4
);
  // Narrow input stream
  logic                i_sig_valid;
  logic                o_sig_ready;
  logic [DW-1:0]       i_sig_data;
  logic                i_sig_last;
  // Wide output stream
  logic                o_sig_valid;
  logic                i_sig_ready;
  logic [DW*RATIO-1:0] o_sig_data;
  logic [RATIO-1:0]    o_sig_keep;
  logic                o_sig_last;
`ifdef SUB_PACK_RX_PARITY_EN
  logic                i_sig_par;
  logic                o_par_err;

  modport slave (
    input  i_sig_valid, i_sig_data, i_sig_last, i_sig_par, i_sig_ready,
    output o_sig_ready, o_sig_valid, o_sig_data, o_sig_keep, o_sig_last, o_par_err
  );
  modport master (
    output i_sig_valid, i_sig_data, i_sig_last, i_sig_par, i_sig_ready,
    input  o_sig_ready, o_sig_valid, o_sig_data, o_sig_keep, o_sig_last, o_par_err
  );
`else
  modport slave (
    input  i_sig_valid, i_sig_data, i_sig_last, i_sig_ready,
    output o_sig_ready, o_sig_valid, o_sig_data, o_sig_keep, o_sig_last
  );
  modport master (
    output i_sig_valid, i_sig_data, i_sig_last, i_sig_ready,
    input  o_sig_ready, o_sig_valid, o_sig_data, o_sig_keep, o_sig_last
  );
`endif
endinterface

// File: rtl/sub_pack_rx.sv
// sub_pack_rx: packs up to RATIO narrow DW-bit words (fewer when a word is
// marked last) into one wide word and buffers packed words in a DEPTH-entry
// first-word-fall-through FIFO toward the sub2 consumers.
// Optional feature macro: SUB_PACK_RX_PARITY_EN (even parity per narrow word;
// a bad word sets a sticky error and drops the rest of its packet).
module sub_pack_rx #(
  parameter int DW    = 8,
  parameter int RATIO = 4,
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  sub_pack_rx_if.slave sig
);

  localparam int WW = DW * RATIO;
  localparam int LW = $clog2(RATIO);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [WW-1:0]    data;
    logic [RATIO-1:0] keep;
    logic             last;
  } entry_t;

`ifdef SUB_PACK_RX_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DROP} state_t;
`else
  typedef enum logic {S_IDLE, S_FILL} state_t;
`endif

  state_t        state_q, state_d;
  logic [LW-1:0] lane_q, lane_d;
  logic [WW-1:0] pack_q, pack_d;
  logic [WW-1:0] merged;
  logic          ready_q;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  entry_t        mem_q [DEPTH];
  entry_t        push_entry;
  entry_t        head;
  logic          acc, push, pop, fifo_valid;

  assign acc        = sig.i_sig_valid & ready_q;
  assign fifo_valid = (count_q != '0);
  assign pop        = fifo_valid & sig.i_sig_ready;
  assign count_d    = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

`ifdef SUB_PACK_RX_PARITY_EN
  logic par_err_q;
  logic par_bad;
  // Even parity over data plus parity bit: any odd count is an error.
  assign par_bad       = ^{sig.i_sig_data, sig.i_sig_par};
  assign sig.o_par_err = par_err_q;
`endif

  // Packing FSM next state: merge the accepted word into its lane and decide on flush.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d = state_q;
    lane_d  = lane_q;
    pack_d  = pack_q;
    push    = 1'b0;
    merged  = (state_q == S_IDLE) ? '0 : pack_q;
    merged[int'(lane_q)*DW +: DW] = sig.i_sig_data;
    push_entry.data = merged;
    for (int k = 0; k < RATIO; k++) begin
      push_entry.keep[k] = (k <= int'(lane_q));
    end
    push_entry.last = sig.i_sig_last;
    if (acc) begin
      unique case (state_q)
        S_IDLE, S_FILL: begin
`ifdef SUB_PACK_RX_PARITY_EN
          if (par_bad) begin
            state_d = sig.i_sig_last ? S_IDLE : S_DROP;
            lane_d  = '0;
          end else
`endif
          if (sig.i_sig_last || lane_q == LW'(RATIO - 1)) begin
            push    = 1'b1;
            state_d = S_IDLE;
            lane_d  = '0;
          end else begin
            pack_d  = merged;
            lane_d  = lane_q + 1'b1;
            state_d = S_FILL;
          end
        end
`ifdef SUB_PACK_RX_PARITY_EN
        S_DROP: begin
          if (sig.i_sig_last) state_d = S_IDLE;
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Control registers: FSM, lane, partial word, FIFO pointers/count, input ready.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      lane_q   <= '0;
      pack_q   <= '0;
      ready_q  <= 1'b0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      pack_q   <= pack_d;
      ready_q  <= (count_d < (AW+1)'(DEPTH));
      count_q  <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // FIFO storage write.
  always_ff @(posedge i_clk) begin
    // NOTE: storage is not reset; the count gates every read, so stale entries are never visible.
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

`ifdef SUB_PACK_RX_PARITY_EN
  // Sticky parity error flag, cleared only by reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)          par_err_q <= 1'b0;
    else if (acc & par_bad) par_err_q <= 1'b1;
  end
`endif

  // First-word-fall-through head; outputs read as zero while the FIFO is empty.
  assign head            = mem_q[rd_ptr_q];
  assign sig.o_sig_ready = ready_q;
  assign sig.o_sig_valid = fifo_valid;
  assign sig.o_sig_data  = fifo_valid ? head.data : '0;
  assign sig.o_sig_keep  = fifo_valid ? head.keep : '0;
  assign sig.o_sig_last  = fifo_valid ? head.last : 1'b0;

endmodule

// File: tb/tb_sub_pack_rx.sv
// Testbench for sub_pack_rx: directed packets, expected packed words queued at
// issue time and compared by an independent output monitor.
module tb_sub_pack_rx;
  localparam int DW    = 8;
  localparam int RATIO = 4;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } exp_t;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  bit   bad_par  = 1'b0;
  exp_t sb[$];

  sub_pack_rx_if #(.DW(DW), .RATIO(RATIO)) sig ();

  sub_pack_rx #(.DW(DW), .RATIO(RATIO), .DEPTH(DEPTH)) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .sig    (sig)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one narrow word and hold it until the DUT accepts it.
  task automatic send(input logic [7:0] d, input logic l);
    int n = 0;
    sig.i_sig_valid = 1'b1;
    sig.i_sig_data  = d;
    sig.i_sig_last  = l;
`ifdef SUB_PACK_RX_PARITY_EN
    sig.i_sig_par   = (^d) ^ bad_par;
`endif
    while (!sig.o_sig_ready && n < 200) begin
      @(posedge i_clk); #1;
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: word 0x%0h not accepted within %0d cycles", d, n);
    end
    @(posedge i_clk); #1;
    sig.i_sig_valid = 1'b0;
    sig.i_sig_last  = 1'b0;
  endtask

  // Send the four bytes of w, lane 0 first, last on the final byte.
  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send(w[i*8 +: 8], i == 3);
  endtask

  // Wait (bounded) until every expected packed word has been observed.
  task automatic drain(input string name);
    int n = 0;
    sig.i_sig_ready = 1'b1;
    while ((sb.size() != 0 || sig.o_sig_valid) && n < 100) begin
      @(posedge i_clk); #1;
      n++;
    end
    check(name, sb.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, sig.o_sig_ready, 0);
    check({tag, "_valid"}, sig.o_sig_valid, 0);
    check({tag, "_data"},  sig.o_sig_data,  0);
    check({tag, "_keep"},  sig.o_sig_keep,  0);
    check({tag, "_last"},  sig.o_sig_last,  0);
`ifdef SUB_PACK_RX_PARITY_EN
    check({tag, "_par_err"}, sig.o_par_err, 0);
`endif
  endtask

  // Output monitor: compare each handshaked packed word against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (i_rst_n && sig.o_sig_valid && sig.i_sig_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got data=0x%h keep=0x%h last=%0b expected none",
                   sig.o_sig_data, sig.o_sig_keep, sig.o_sig_last);
        end else begin
          e = sb.pop_front();
          check("pkt_data", sig.o_sig_data, e.data);
          check("pkt_keep", sig.o_sig_keep, e.keep);
          check("pkt_last", sig.o_sig_last, e.last);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pk [4];
    pk[0] = 32'h34333231;
    pk[1] = 32'h44434241;
    pk[2] = 32'h54535251;
    pk[3] = 32'h64636261;

    sig.i_sig_valid = 1'b0;
    sig.i_sig_data  = '0;
    sig.i_sig_last  = 1'b0;
    sig.i_sig_ready = 1'b0;
`ifdef SUB_PACK_RX_PARITY_EN
    sig.i_sig_par   = 1'b0;
`endif

    // Reset state, then ready rises on the first edge after release.
    repeat (2) @(posedge i_clk); #1;
    check_reset_outputs("reset");
    @(negedge i_clk); i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    check("ready_after_reset", sig.o_sig_ready, 1);

    // Test 1: full 4-word packet, valid right after the final accepting edge.
    sig.i_sig_ready = 1'b1;
    sb.push_back('{32'h44332211, 4'hF, 1'b1});
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 1);
    check("t1_valid_latency", sig.o_sig_valid, 1);
    drain("t1_drained");

    // Test 2: short packet, unfilled lanes zero.
    sb.push_back('{32'h0000A2A1, 4'h3, 1'b1});
    send(8'hA1, 0); send(8'hA2, 1);
    drain("t2_drained");

    // Test 3: downstream stalled, fill FIFO with four packets.
    sig.i_sig_ready = 1'b0;
    for (int p = 0; p < 4; p++) begin
      sb.push_back('{pk[p], 4'hF, 1'b1});
      send_word(pk[p]);
    end
    check("t3_ready_fell", sig.o_sig_ready, 0);
    check("t3_valid_full", sig.o_sig_valid, 1);
    sb.push_back('{32'hE4E3E2E1, 4'hF, 1'b1});
    sig.i_sig_valid = 1'b1;
    sig.i_sig_data  = 8'hE1;
    sig.i_sig_last  = 1'b0;
`ifdef SUB_PACK_RX_PARITY_EN
    sig.i_sig_par   = ^sig.i_sig_data;
`endif
    repeat (5) begin @(posedge i_clk); #1; end
    check("t3_no_accept_full", sig.o_sig_ready, 0);
    check("t3_head_stable", sig.o_sig_data, 32'h34333231);

    // Test 4: one pop reopens the input on the next edge; order preserved on drain.
    sig.i_sig_ready = 1'b1;
    @(posedge i_clk); #1;
    sig.i_sig_ready = 1'b0;
    check("t4_ready_back", sig.o_sig_ready, 1);
    send(8'hE1, 0); send(8'hE2, 0); send(8'hE3, 0); send(8'hE4, 1);
    drain("t4_drained");

    // Test 5: reset mid-packet with a stored word discards everything.
    sig.i_sig_ready = 1'b0;
    send_word(32'hF4F3F2F1);
    send(8'h91, 0); send(8'h92, 0);
    i_rst_n = 1'b0;
    #2;
    check_reset_outputs("t5_reset");
    @(negedge i_clk); i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    sig.i_sig_ready = 1'b1;
    sb.push_back('{32'h0000B2B1, 4'h3, 1'b1});
    send(8'hB1, 0); send(8'hB2, 1);
    drain("t5_drained");

`ifdef SUB_PACK_RX_PARITY_EN
    // Test 6: bad parity on word 2 drops the packet; next good packet passes.
    send(8'hC1, 0);
    bad_par = 1'b1;
    send(8'hC2, 0);
    bad_par = 1'b0;
    send(8'hC3, 0); send(8'hC4, 1);
    check("t6_par_err", sig.o_par_err, 1);
    check("t6_no_push", sig.o_sig_valid, 0);
    sb.push_back('{32'h0000D2D1, 4'h3, 1'b1});
    send(8'hD1, 0); send(8'hD2, 1);
    drain("t6_drained");
`endif

    repeat (3) begin @(posedge i_clk); #1; end
    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
